// File: rtl/pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pwr_seq_ctrl
// Power-sequencing controller for N_DOM switchable domains. A single shared
// sequencer services one domain at a time and drives retention save,
// isolation, power switch and restore in a fixed safe order.
//
// Ports
//   clk      : sole clock, rising edge
//   rst      : synchronous reset, active-high
//   req_off  : per-domain one-cycle power-down request
//   req_on   : per-domain one-cycle power-up request
//   sw_ctr   : per-domain power switch control (0 = ON, 1 = OFF)
//   iso      : per-domain isolation enable
//   save     : retention save strobe (active domain only)
//   restore  : retention restore strobe (active domain only)
//   dom_on   : committed domain state (1 = on)
//   busy     : sequencer not idle
//   done     : one-cycle pulse when a domain's sequence completes
//   err      : one-cycle pulse after simultaneous on/off request
// -----------------------------------------------------------------------------
module pwr_seq_ctrl #(
   parameter int N_DOM       = 2,
   parameter int CNT_W       = 8,
   parameter int SAVE_CYC    = 2,
   parameter int ISO_CYC     = 2,
   parameter int OFF_WAIT    = 4,
   parameter int ON_WAIT     = 4,
   parameter int RESTORE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_DOM-1:0] req_off,
   input  logic [N_DOM-1:0] req_on,
   output logic [N_DOM-1:0] sw_ctr,
   output logic [N_DOM-1:0] iso,
   output logic [N_DOM-1:0] save,
   output logic [N_DOM-1:0] restore,
   output logic [N_DOM-1:0] dom_on,
   output logic             busy,
   output logic [N_DOM-1:0] done,
   output logic             err
);

   localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
   localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_DOM - 1);

   // Timer load value: a phase of c cycles loads c-1; 0 behaves like 1.
   function automatic logic [CNT_W-1:0] ld_val(input int cyc);
      logic [CNT_W-1:0] v;
      if (cyc < 2) begin
         v = {CNT_W{1'b0}};
      end else begin
         v = CNT_W'(cyc - 1);
      end
      return v;
   endfunction

   localparam logic [CNT_W-1:0] SAVE_LD    = ld_val(SAVE_CYC);
   localparam logic [CNT_W-1:0] ISO_LD     = ld_val(ISO_CYC);
   localparam logic [CNT_W-1:0] OFF_LD     = ld_val(OFF_WAIT);
   localparam logic [CNT_W-1:0] ON_LD      = ld_val(ON_WAIT);
   localparam logic [CNT_W-1:0] RESTORE_LD = ld_val(RESTORE_CYC);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   // One-hot decode of a domain index.
   function automatic logic [N_DOM-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_DOM-1:0] v;
      v      = {N_DOM{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin scan position k places above the last granted index.
   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
      int raw;
      raw = int'(base) + 1 + k;
      if (raw >= N_DOM) begin
         raw = raw - N_DOM;
      end else begin
         raw = raw;
      end
      return IDX_W'(raw);
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SAVE    = 3'd1,
      ST_ISO_ON  = 3'd2,
      ST_SW_OFF  = 3'd3,
      ST_SW_ON   = 3'd4,
      ST_RESTORE = 3'd5,
      ST_ISO_OFF = 3'd6,
      ST_DONE    = 3'd7
   } state_t;

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [IDX_W-1:0] act_r, act_s;
   logic [IDX_W-1:0] ptr_r, ptr_s;
   logic [N_DOM-1:0] tgt_r, tgt_s;
   logic [N_DOM-1:0] iso_r, iso_s;
   logic [N_DOM-1:0] sw_r, sw_s;
   logic [N_DOM-1:0] dom_on_r, dom_on_s;
   logic [N_DOM-1:0] save_r, save_s;
   logic [N_DOM-1:0] restore_r, restore_s;
   logic [N_DOM-1:0] done_r, done_s;
   logic             busy_r, busy_s;
   logic             err_r, err_s;
   logic [N_DOM-1:0] pend_s;
   logic [N_DOM-1:0] act_oh_s;
   logic             grant_vld_s;
   logic [IDX_W-1:0] grant_idx_s;

   // Pending domains and round-robin winner (only consumed in IDLE).
   always_comb begin
      act_oh_s    = onehot(act_r);
      grant_vld_s = 1'b0;
      grant_idx_s = {IDX_W{1'b0}};
      if (state_r != ST_IDLE) begin
         pend_s = (tgt_r ^ dom_on_r) & ~act_oh_s;
      end else begin
         pend_s = tgt_r ^ dom_on_r;
      end
      for (int k = 0; k < N_DOM; k++) begin
         if (!grant_vld_s && pend_s[rr_idx(ptr_r, k)]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = rr_idx(ptr_r, k);
         end else begin
            grant_vld_s = grant_vld_s;
            grant_idx_s = grant_idx_s;
         end
      end
   end

   // Next-state, phase timer and per-domain control register updates.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      act_s    = act_r;
      ptr_s    = ptr_r;
      iso_s    = iso_r;
      sw_s     = sw_r;
      dom_on_s = dom_on_r;
      err_s    = |(req_on & req_off);
      // Simultaneous on/off leaves the target untouched.
      tgt_s    = (tgt_r | (req_on & ~req_off)) & ~(req_off & ~req_on);
      case (state_r)
         ST_IDLE: begin
            if (grant_vld_s) begin
               act_s = grant_idx_s;
               ptr_s = grant_idx_s;
               if (tgt_r[grant_idx_s]) begin
                  state_s = ST_SW_ON;
                  cnt_s   = ON_LD;
                  sw_s    = sw_r & ~onehot(grant_idx_s);
               end else begin
                  state_s = ST_SAVE;
                  cnt_s   = SAVE_LD;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SAVE: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_ISO_ON;
               cnt_s   = ISO_LD;
               iso_s   = iso_r | act_oh_s;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         ST_ISO_ON: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_SW_OFF;
               cnt_s   = OFF_LD;
               sw_s    = sw_r | act_oh_s;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         ST_SW_OFF: begin
            if (cnt_r == CNT_ZERO) begin
               state_s  = ST_DONE;
               dom_on_s = dom_on_r & ~act_oh_s;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         ST_SW_ON: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_RESTORE;
               cnt_s   = RESTORE_LD;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         ST_RESTORE: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_ISO_OFF;
               cnt_s   = CNT_ZERO;
               iso_s   = iso_r & ~act_oh_s;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         ST_ISO_OFF: begin
            state_s  = ST_DONE;
            dom_on_s = dom_on_r | act_oh_s;
         end
         ST_DONE: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // Strobe decodes of the upcoming state so the outputs leave a flop.
   always_comb begin
      busy_s    = (state_s != ST_IDLE);
      save_s    = (state_s == ST_SAVE)    ? onehot(act_s) : {N_DOM{1'b0}};
      restore_s = (state_s == ST_RESTORE) ? onehot(act_s) : {N_DOM{1'b0}};
      done_s    = (state_s == ST_DONE)    ? onehot(act_s) : {N_DOM{1'b0}};
   end

   // State and output registers; reset returns every domain to powered-on.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= CNT_ZERO;
         act_r     <= {IDX_W{1'b0}};
         ptr_r     <= PTR_RST;
         tgt_r     <= {N_DOM{1'b1}};
         iso_r     <= {N_DOM{1'b0}};
         sw_r      <= {N_DOM{1'b0}};
         dom_on_r  <= {N_DOM{1'b1}};
         save_r    <= {N_DOM{1'b0}};
         restore_r <= {N_DOM{1'b0}};
         done_r    <= {N_DOM{1'b0}};
         busy_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         act_r     <= act_s;
         ptr_r     <= ptr_s;
         tgt_r     <= tgt_s;
         iso_r     <= iso_s;
         sw_r      <= sw_s;
         dom_on_r  <= dom_on_s;
         save_r    <= save_s;
         restore_r <= restore_s;
         done_r    <= done_s;
         busy_r    <= busy_s;
         err_r     <= err_s;
      end
   end

   assign sw_ctr  = sw_r;
   assign iso     = iso_r;
   assign save    = save_r;
   assign restore = restore_r;
   assign dom_on  = dom_on_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign err     = err_r;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwr_seq_ctrl
// Self-checking bench for pwr_seq_ctrl (N_DOM=2, default timing). A directed
// cycle table, hand-written corner sequences and a random phase are all
// compared every cycle against a sequence-offset reference model.
// -----------------------------------------------------------------------------
module tb_pwr_seq_ctrl;

   localparam int N  = 2;
   localparam int S  = 2;
   localparam int I  = 2;
   localparam int W  = 4;
   localparam int ON = 4;
   localparam int R  = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req_off = '0;
   logic [N-1:0] req_on  = '0;
   logic [N-1:0] sw_ctr, iso, save, restore, dom_on, done;
   logic         busy, err;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   pwr_seq_ctrl #(
      .N_DOM(N), .CNT_W(8), .SAVE_CYC(S), .ISO_CYC(I),
      .OFF_WAIT(W), .ON_WAIT(ON), .RESTORE_CYC(R)
   ) dut (
      .clk(clk), .rst(rst), .req_off(req_off), .req_on(req_on),
      .sw_ctr(sw_ctr), .iso(iso), .save(save), .restore(restore),
      .dom_on(dom_on), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Reference model: tracks the active sequence as an offset from its
   // first busy cycle and applies each phase event at its offset.
   bit [N-1:0] m_tgt = '1, m_on = '1, m_iso = '0, m_sw = '0;
   bit [N-1:0] m_save = '0, m_rest = '0, m_done = '0;
   bit         m_err = 1'b0, m_busy = 1'b0, m_up = 1'b0;
   int         m_t = 0, m_len = 0, m_dom = 0, m_ptr = N - 1;

   always @(posedge clk) begin
      if (rst) begin
         m_tgt = '1; m_on = '1; m_iso = '0; m_sw = '0;
         m_save = '0; m_rest = '0; m_done = '0;
         m_err = 1'b0; m_busy = 1'b0; m_t = 0; m_ptr = N - 1;
      end else begin
         m_save = '0; m_rest = '0; m_done = '0;
         if (m_busy) begin
            m_t = m_t + 1;
            if (m_t == m_len) m_busy = 1'b0;
         end else begin
            for (int k = 0; k < N; k++) begin
               if (!m_busy && (m_tgt[(m_ptr + 1 + k) % N] != m_on[(m_ptr + 1 + k) % N])) begin
                  m_dom  = (m_ptr + 1 + k) % N;
                  m_ptr  = m_dom;
                  m_busy = 1'b1;
                  m_t    = 0;
                  m_up   = m_tgt[m_dom];
                  m_len  = m_up ? (ON + R + 2) : (S + I + W + 1);
               end
            end
         end
         if (m_busy) begin
            if (!m_up) begin
               if (m_t < S)         m_save[m_dom] = 1'b1;
               if (m_t == S)        m_iso[m_dom]  = 1'b1;
               if (m_t == S + I)    m_sw[m_dom]   = 1'b1;
               if (m_t == S + I + W) begin m_done[m_dom] = 1'b1; m_on[m_dom] = 1'b0; end
            end else begin
               if (m_t == 0)                  m_sw[m_dom]   = 1'b0;
               if (m_t >= ON && m_t < ON + R) m_rest[m_dom] = 1'b1;
               if (m_t == ON + R)             m_iso[m_dom]  = 1'b0;
               if (m_t == ON + R + 1) begin m_done[m_dom] = 1'b1; m_on[m_dom] = 1'b1; end
            end
         end
         m_err = |(req_on & req_off);
         m_tgt = (m_tgt | (req_on & ~req_off)) & ~(req_off & ~req_on);
      end
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h time=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic check_model();
      check("model", {18'd0, save, iso, sw_ctr, restore, dom_on, done, busy, err},
                     {18'd0, m_save, m_iso, m_sw, m_rest, m_on, m_done, m_busy, m_err});
      check("inv_sw_iso", {30'd0, sw_ctr & ~iso}, 32'd0);
      check("inv_save_restore", {30'd0, save & restore}, 32'd0);
      check("inv_done_onehot", {31'd0, ($countones(done) > 1)}, 32'd0);
   endtask

   task automatic tick();
      @(negedge clk);
      if (chk_en) check_model();
   endtask

   task automatic wait_done(input int d, input int maxc, output int n);
      n = 0;
      while (done[d] !== 1'b1 && n < maxc) begin
         tick();
         n++;
      end
      check("wait_done_timeout", {31'd0, (n >= maxc)}, 32'd0);
   endtask

   typedef struct {
      logic [1:0] on, off, sv, is, sw, rs, don, dn;
      logic       bsy, er;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] on, off, sv, is, sw, rs, don,
                               input logic bsy, input logic [1:0] dn, input logic er);
      vec_t v;
      v.on = on; v.off = off; v.sv = sv; v.is = is; v.sw = sw; v.rs = rs;
      v.don = don; v.bsy = bsy; v.dn = dn; v.er = er;
      return v;
   endfunction

   vec_t tbl[$];
   int   n;
   bit   bad, seen0;

   initial begin
      // Power-down of domain 1 from reset (rows are consecutive cycles).
      tbl.push_back(mk(2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0));
      for (int k = 6; k <= 9; k++)
         tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 1'b1, 2'b10, 1'b0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0));
      // Power-up of domain 1.
      tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0));
      for (int k = 2; k <= 5; k++)
         tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b10, 1'b0));
      // Idle, then illegal simultaneous request, then redundant req_on[0].
      tbl.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 1'b1));
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0));

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst = 1'b0;
      tick();

      for (int k = 0; k < tbl.size(); k++) begin
         check($sformatf("vec%0d", k),
               {17'd0, save, iso, sw_ctr, restore, dom_on, busy, done, err},
               {17'd0, tbl[k].sv, tbl[k].is, tbl[k].sw, tbl[k].rs, tbl[k].don,
                tbl[k].bsy, tbl[k].dn, tbl[k].er});
         req_on  = tbl[k].on;
         req_off = tbl[k].off;
         tick();
      end
      req_on = '0; req_off = '0;

      // Round robin: both domains off together, domain 0 first.
      req_off = 2'b11; tick(); req_off = 2'b00;
      wait_done(0, 40, n);
      check("rr_done0_lat", n, 9);
      tick();
      check("rr_gap_save", {30'd0, save}, 32'd0);
      tick();
      check("rr_save1_start", {30'd0, save}, 32'd2);
      wait_done(1, 40, n);
      check("rr_done1_lat", n, 8);
      tick();
      req_on = 2'b11; tick(); req_on = 2'b00;
      tick();
      check("rr_next_grant_dom0", {30'd0, sw_ctr}, 32'd2);
      wait_done(0, 40, n);
      check("rr_up0_lat", n, 7);
      wait_done(1, 40, n);
      check("rr_up1_lat", n, 9);
      tick();

      // Cancel: domain 1 pending behind domain 0, reversed before grant.
      req_off = 2'b11; tick(); req_off = 2'b00;
      tick(); tick();
      req_on = 2'b10; tick(); req_on = 2'b00;
      bad = 1'b0; seen0 = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (done[1] || save[1] || sw_ctr[1]) bad = 1'b1;
         if (done[0]) seen0 = 1'b1;
         tick();
      end
      check("cancel_dom1_untouched", {31'd0, bad}, 32'd0);
      check("cancel_dom0_done", {31'd0, seen0}, 32'd1);
      check("cancel_dom_on", {30'd0, dom_on}, 32'd2);
      req_on = 2'b01; tick(); req_on = 2'b00;
      wait_done(0, 40, n);
      tick();

      // Reset in cycle 7 of a power-down.
      req_off = 2'b01; tick(); req_off = 2'b00;
      repeat (6) tick();
      rst = 1'b1; tick();
      check("rst_mid_outputs", {22'd0, sw_ctr, iso, dom_on, save, busy, 1'b0},
                               {22'd0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0});
      rst = 1'b0; tick();
      req_off = 2'b10; tick(); req_off = 2'b00;
      wait_done(1, 40, n);
      check("post_rst_lat", n, 9);
      check("post_rst_dom_on", {30'd0, dom_on}, 32'd1);
      req_on = 2'b10; tick(); req_on = 2'b00;
      wait_done(1, 40, n);
      tick();

      // Random phase against the model.
      for (int k = 0; k < 3000; k++) begin
         req_on  = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
         req_off = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
         rst     = ($urandom_range(0, 499) == 0);
         tick();
      end
      req_on = '0; req_off = '0; rst = 1'b0;
      repeat (40) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
